// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, FSM encoding and GF(2^8) byte/column helpers (inverse helpers used only with AES_DECRYPT_EN)
package aes_pkg;
  typedef logic [127:0] state_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
  function automatic int nr_of(input int key_bits);
    return key_bits == 128 ? 10 : key_bits == 192 ? 12 : key_bits == 256 ? 14 : 0;
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p ^= b[i] ? x : 8'h00;
      x = xtime(x);
    end
    return p;
  endfunction
  // multiplicative inverse as a^254 by square-and-multiply; 0 maps to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] s, r;
    s = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction
  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction
  function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction
endpackage

// File: rtl/aes_iter_core_if.sv
// aes_iter_core_if: block stream in/out handshakes plus expanded round keys; mode_i exists only with AES_DECRYPT_EN
interface aes_iter_core_if import aes_pkg::*; #(parameter int KEY_BITS = 128);
  localparam int NR = nr_of(KEY_BITS);
  logic valid_i, ready_o, valid_o, ready_i;
  state_t data_i, data_o;
  state_t [NR:0] round_key_i;
`ifdef AES_DECRYPT_EN
  logic mode_i;
`endif
  modport master (
    output valid_i, data_i, round_key_i, ready_i,
`ifdef AES_DECRYPT_EN
    output mode_i,
`endif
    input ready_o, valid_o, data_o
  );
  modport slave (
    input valid_i, data_i, round_key_i, ready_i,
`ifdef AES_DECRYPT_EN
    input mode_i,
`endif
    output ready_o, valid_o, data_o
  );
endinterface

// File: rtl/aes_round.sv
// aes_round: one combinational AES round (final round skips column mixing); inverse round added with AES_DECRYPT_EN
module aes_round import aes_pkg::*; (
  input  state_t state,
  input  state_t round_key,
  input  logic   final_round,
`ifdef AES_DECRYPT_EN
  input  logic   mode,
`endif
  output state_t next_state
);
  state_t enc, mix;
`ifdef AES_DECRYPT_EN
  state_t dec, dec_mix;
`endif
  // bytes are column-major: byte r+4c is row r, column c
  always_comb begin
    enc = '0;
    mix = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        enc[127 - 8*(r + 4*c) -: 8] = sbox(state[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
    for (int c = 0; c < 4; c++)
      mix[127 - 32*c -: 32] = mix_column(enc[127 - 32*c -: 32]);
`ifdef AES_DECRYPT_EN
    dec = '0;
    dec_mix = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        dec[127 - 8*(r + 4*c) -: 8] = inv_sbox(state[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8]);
    dec = dec ^ round_key;
    for (int c = 0; c < 4; c++)
      dec_mix[127 - 32*c -: 32] = inv_mix_column(dec[127 - 32*c -: 32]);
    next_state = mode ? (final_round ? dec : dec_mix) : (final_round ? enc : mix) ^ round_key;
`else
    next_state = (final_round ? enc : mix) ^ round_key;
`endif
  end
endmodule

// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128/192/256 core, one round per clock, valid/ready on both sides; AES_DECRYPT_EN adds decryption
module aes_iter_core import aes_pkg::*; #(parameter int KEY_BITS = 128) (
  input logic clk,
  input logic rst_n,
  aes_iter_core_if.slave bus
);
  localparam int NR = nr_of(KEY_BITS);
  localparam int RW = $clog2(NR + 1);
  localparam logic [RW-1:0] LAST = RW'(NR);
  if (NR == 0) begin : g_bad_key_bits
    $error("aes_iter_core: KEY_BITS must be 128, 192 or 256");
  end
  fsm_t st, st_d;
  logic [RW-1:0] rnd, key_idx;
  state_t blk, nxt, init_key;
  logic accept, last;
`ifdef AES_DECRYPT_EN
  logic mode_q;
  assign key_idx = mode_q ? LAST - rnd : rnd;
  assign init_key = bus.mode_i ? bus.round_key_i[NR] : bus.round_key_i[0];
`else
  assign key_idx = rnd;
  assign init_key = bus.round_key_i[0];
`endif
  assign last = rnd == LAST;
  assign bus.ready_o = rst_n && (st == IDLE || (st == DONE && bus.ready_i));
  assign bus.valid_o = st == DONE;
  assign accept = bus.valid_i && bus.ready_o;
  aes_round u_round (
    .state(blk),
    .round_key(bus.round_key_i[key_idx]),
    .final_round(last),
`ifdef AES_DECRYPT_EN
    .mode(mode_q),
`endif
    .next_state(nxt)
  );
  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= st_d;
  // next state: an accept always starts a run, otherwise run to completion and hold the result until taken
  always_comb
    st_d = accept ? RUN : (st == RUN && !last) ? RUN : (st == RUN || (st == DONE && !bus.ready_i)) ? DONE : IDLE;
  // datapath: load whitened block on accept, apply one round per cycle, publish after the last round
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      blk <= '0;
      rnd <= '0;
      bus.data_o <= '0;
`ifdef AES_DECRYPT_EN
      mode_q <= 1'b0;
`endif
    end else if (accept) begin
      blk <= bus.data_i ^ init_key;
      rnd <= RW'(1);
`ifdef AES_DECRYPT_EN
      mode_q <= bus.mode_i;
`endif
    end else if (st == RUN) begin
      blk <= nxt;
      rnd <= last ? '0 : rnd + 1'b1;
      if (last) bus.data_o <= nxt;
    end
endmodule
